instr_encoder: RTL and testbench

//  Encoder counterpart of the immediate generator: packs format, opcode, register fields and a 64-bit immediate into one 32-bit RV64I word.

---
 rtl/instr_enc_pkg.sv | 63 ++++++
 rtl/instr_encoder_if.sv | 38 +++
 rtl/instr_enc_range_chk.sv | 34 +++
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types, constants and immediate-placement helpers for the RV64I
// instruction encoder.
//   fmt_t    : request format code (R/I/S/B/U/J/LI; code 7 is undefined)
//   state_t  : encoder output FSM state, also exported on the debug port
//   OP_LUI / OP_IMM / NOP : opcodes and the no-op word used for the LI
//              expansion and for rejected requests
//   place_*  : move immediate bits into their instruction-word positions
//   li_hi    : upper 20 bits for the LUI half of an LI expansion
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_LI = 3'd6
    } fmt_t;

    // ST_IDLE: output register empty
    // ST_ONE : last (or only) word of a request is on the output
    // ST_HI  : LUI half of an LI is on the output, ADDI half held back
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    localparam int          XLEN_DEFAULT = 64;
    localparam logic [6:0]  OP_LUI       = 7'b0110111;
    localparam logic [6:0]  OP_IMM       = 7'b0010011;
    localparam logic [31:0] NOP          = 32'h00000013;

    function automatic logic [31:0] place_i(input logic [11:0] imm);
        return {imm, 20'b0};
    endfunction

    function automatic logic [31:0] place_s(input logic [11:0] imm);
        return {imm[11:5], 13'b0, imm[4:0], 7'b0};
    endfunction

    // B immediates are byte offsets; bit 0 is never encoded.
    function automatic logic [31:0] place_b(input logic [12:1] imm);
        return {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
    endfunction

    function automatic logic [31:0] place_u(input logic [31:12] imm);
        return {imm, 12'b0};
    endfunction

    // J immediates are byte offsets; bit 0 is never encoded.
    function automatic logic [31:0] place_j(input logic [20:1] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
    endfunction

    // ADDI sign-extends its 12-bit immediate, so the LUI part is rounded
    // up by 0x800 to cancel a negative low half.
    function automatic logic [19:0] li_hi(input logic [31:0] imm);
        return 20'((imm + 32'h0000_0800) >> 12);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between a program loader and the instruction
// encoder.
//   req_*  : one encode request, valid/ready handshake
//   out_*  : encoded word stream, valid/ready handshake
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both high; a source holding valid keeps its
// payload stable until that edge, and ready may depend on the sink's state.
// master: request producer / word consumer; slave: the encoder.
interface instr_encoder_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_fmt;
    logic [6:0]      req_opcode;
    logic [4:0]      req_rd;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [2:0]      req_funct3;
    logic [6:0]      req_funct7;
    logic [XLEN-1:0] req_imm;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic            out_err;

    modport master (
        output req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  req_valid, req_fmt, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/instr_enc_range_chk.sv
// Combinational immediate range check for the instruction encoder. Only
// instantiated when INSTR_ENC_RANGE_CHECK_EN is defined.
//   fmt : request format
//   imm : immediate, already sign-extended to 64 bits
//   ok  : 1 when imm fits the format's immediate field
module instr_enc_range_chk
    import instr_enc_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [63:0] imm,
    output logic        ok
);
    // A value fits in N signed bits when bits [63:N-1] are all equal.
    logic fits12, fits13, fits21, fits32, li_wrap;

    always_comb begin
        fits12  = (&imm[63:11]) || !(|imm[63:11]);
        fits13  = (&imm[63:12]) || !(|imm[63:12]);
        fits21  = (&imm[63:20]) || !(|imm[63:20]);
        fits32  = (&imm[63:31]) || !(|imm[63:31]);
        // 0x7FFFF800..0x7FFFFFFF round the LUI half past 0x7FFFF000.
        li_wrap = (imm[31:11] == {1'b0, 20'hFFFFF});
        ok = 1'b0;
        case (fmt)
            FMT_R:        ok = 1'b1;
            FMT_I, FMT_S: ok = fits12;
            FMT_B:        ok = fits13 && !imm[0];
            FMT_J:        ok = fits21 && !imm[0];
            FMT_U:        ok = fits32 && (imm[11:0] == 12'h000);
            FMT_LI:       ok = fits32 && !li_wrap;
            default:      ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// Encodes format, opcode, register fields and an immediate into one 32-bit
// RV64I word; LI expands to one or two words (LUI then ADDI). Output is
// registered, one word per cycle at full rate.
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN enables immediate range
// checking (bad requests produce a single NOP_INSTR word with out_err=1).
// Without it immediates are truncated to field width and out_err stays 0.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : instr_encoder_if slave (req_* in, out_* out)
//   dbg_state : current FSM state
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int          XLEN      = XLEN_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output state_t           dbg_state
);
    state_t      state_q, state_n;
    logic [31:0] instr_q, instr_n;
    logic        err_q, err_n;
    logic [31:0] held_q, held_n;

    fmt_t        fmt;
    logic [63:0] imm64;
    logic [11:0] li_lo;
    logic [19:0] li_hi_v;
    logic [31:0] word, addi_word;
    logic        two_beat, enc_err, accept;
    logic        unused_imm_hi;

    assign fmt           = fmt_t'(bus.req_fmt);
    assign imm64         = 64'($signed(bus.req_imm));
    assign unused_imm_hi = ^imm64[63:32];

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic range_ok;
    instr_enc_range_chk u_range_chk (
        .fmt (fmt),
        .imm (imm64),
        .ok  (range_ok)
    );
`endif

    // Encode the current request; word is the first beat, addi_word the
    // second beat when two_beat is set.
    always_comb begin
        word      = NOP_INSTR;
        addi_word = 32'h0;
        two_beat  = 1'b0;
        enc_err   = 1'b0;
        li_lo     = imm64[11:0];
        li_hi_v   = li_hi(imm64[31:0]);
        case (fmt)
            FMT_R: word = {bus.req_funct7, bus.req_rs2, bus.req_rs1,
                           bus.req_funct3, bus.req_rd, bus.req_opcode};
            FMT_I: word = place_i(imm64[11:0]) |
                          {12'b0, bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode};
            FMT_S: word = place_s(imm64[11:0]) |
                          {7'b0, bus.req_rs2, bus.req_rs1, bus.req_funct3, 5'b0, bus.req_opcode};
            FMT_B: word = place_b(imm64[12:1]) |
                          {7'b0, bus.req_rs2, bus.req_rs1, bus.req_funct3, 5'b0, bus.req_opcode};
            FMT_U: word = place_u(imm64[31:12]) | {20'b0, bus.req_rd, bus.req_opcode};
            FMT_J: word = place_j(imm64[20:1]) | {20'b0, bus.req_rd, bus.req_opcode};
            FMT_LI: begin
                if (li_hi_v == 20'h0) begin
                    word = {li_lo, 5'd0, 3'b000, bus.req_rd, OP_IMM};
                end else if (li_lo == 12'h0) begin
                    word = {li_hi_v, bus.req_rd, OP_LUI};
                end else begin
                    word      = {li_hi_v, bus.req_rd, OP_LUI};
                    addi_word = {li_lo, bus.req_rd, 3'b000, bus.req_rd, OP_IMM};
                    two_beat  = 1'b1;
                end
            end
            default: word = NOP_INSTR;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if (!range_ok) begin
            word     = NOP_INSTR;
            two_beat = 1'b0;
            enc_err  = 1'b1;
        end
`endif
    end

    // No accept in ST_HI: the output register still owes the ADDI beat.
    assign bus.req_ready = (state_q == ST_IDLE) || (bus.out_ready && state_q == ST_ONE);
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_n = state_q;
        instr_n = instr_q;
        err_n   = err_q;
        held_n  = held_q;
        case (state_q)
            ST_IDLE, ST_ONE: begin
                if (accept) begin
                    instr_n = word;
                    err_n   = enc_err;
                    held_n  = addi_word;
                    state_n = two_beat ? ST_HI : ST_ONE;
                end else if (state_q == ST_ONE && bus.out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            ST_HI: begin
                if (bus.out_ready) begin
                    instr_n = held_q;
                    err_n   = 1'b0;
                    state_n = ST_ONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            held_q  <= 32'h0;
        end else begin
            state_q <= state_n;
            instr_q <= instr_n;
            err_q   <= err_n;
            held_q  <= held_n;
        end
    end

    assign bus.out_valid = (state_q != ST_IDLE);
    assign bus.out_instr = instr_q;
    assign bus.out_err   = err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder. Expected words are hand-encoded
// RV64I constants. Checks adapt to INSTR_ENC_RANGE_CHECK_EN when defined.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;
    logic [31:0] exp_q[$];

    instr_encoder_if #(.XLEN(64)) bus ();

    instr_encoder #(.XLEN(64), .NOP_INSTR(32'h00000013)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_fmt    = 3'd0;
        bus.req_opcode = 7'd0;
        bus.req_rd     = 5'd0;
        bus.req_rs1    = 5'd0;
        bus.req_rs2    = 5'd0;
        bus.req_funct3 = 3'd0;
        bus.req_funct7 = 7'd0;
        bus.req_imm    = 64'd0;
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [63:0] imm);
        bus.req_fmt    = fmt;
        bus.req_opcode = op;
        bus.req_rd     = rd;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_funct3 = f3;
        bus.req_funct7 = f7;
        bus.req_imm    = imm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge,
    // when the first output word is already registered.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] imm);
        int n = 0;
        set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: req_ready=%b required 1 within 50 cycles", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [31:0] instr, input logic err);
        // inline comparison of the registered output after an accept
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== instr || bus.out_err !== err) begin
            errors++;
            $display("FAIL %s: valid=%b instr=%h err=%b required valid=1 instr=%h err=%b",
                     name, bus.out_valid, bus.out_instr, bus.out_err, instr, err);
        end
    endtask

    task automatic drain_check(input string name);
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s: out_valid=%b required 0", name, bus.out_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h err=%b required 0/00000000/0",
                     bus.out_valid, bus.out_instr, bus.out_err);
        end
        checks++;
        if (bus.req_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b state=%0d required 1/IDLE",
                     bus.req_ready, dbg_state);
        end
    endtask

    task automatic test_i_type();
        bus.out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, -64'sd1);
        expect_word("i_addi_m1", 32'hFFF08293, 1'b0);
        drain_check("i_drain");
    endtask

    task automatic test_b_type();
        bus.out_ready = 1'b1;
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8);
        expect_word("b_beq_8", 32'h00208463, 1'b0);
        drain_check("b_drain");
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        expect_word("b_odd_err", 32'h00000013, 1'b1);
`else
        expect_word("b_odd_trunc", 32'h00208163, 1'b0);
`endif
        drain_check("b_err_single_beat");
    endtask

    task automatic test_formats();
        bus.out_ready = 1'b1;
        send(3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, -64'sd4);
        expect_word("s_sw_m4", 32'hFE312E23, 1'b0);
        send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
        expect_word("u_lui", 32'h123450B7, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd8);
        expect_word("j_jal_8", 32'h008000EF, 1'b0);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'hDEAD_BEEF_0000_0FFF);
        expect_word("r_sub", 32'h402081B3, 1'b0);
        send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        expect_word("fmt_undef", 32'h00000013, 1'b1);
`else
        expect_word("fmt_undef", 32'h00000013, 1'b0);
`endif
        drain_check("formats_drain");
    endtask

    task automatic test_li();
        bus.out_ready = 1'b0;
        send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345FFF);
        expect_word("li_lui", 32'h12346537, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_instr !== 32'h12346537 || bus.out_valid !== 1'b1 ||
                bus.req_ready !== 1'b0 || dbg_state !== ST_HI) begin
                errors++;
                $display("FAIL li_hold_%0d: instr=%h valid=%b ready=%b state=%0d required 12346537/1/0/HI",
                         i, bus.out_instr, bus.out_valid, bus.req_ready, dbg_state);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        expect_word("li_addi", 32'hFFF50513, 1'b0);
        checks++;
        if (dbg_state !== ST_ONE) begin
            errors++;
            $display("FAIL li_addi_state: state=%0d required ONE", dbg_state);
        end
        drain_check("li_drain");
        send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
        expect_word("li_small", 32'h00500513, 1'b0);
        drain_check("li_small_single");
        send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
        expect_word("li_lui_only", 32'h12345537, 1'b0);
        drain_check("li_lui_only_single");
    endtask

    task automatic test_range();
        bus.out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        expect_word("i_2048", 32'h00000013, 1'b1);
`else
        expect_word("i_2048", 32'h80000013, 1'b0);
`endif
        send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2047);
        expect_word("i_2047", 32'h7FF00013, 1'b0);
        drain_check("range_drain");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        bus.out_ready = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_req(3'd1, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 64'(i * 3));
            exp_q.push_back({12'(i * 3), 5'd0, 3'd0, 5'(i + 1), 7'h13});
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: req_ready=%b required 1", i, bus.req_ready);
            end
            @(posedge clk); #1;
            exp_w = exp_q.pop_front();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_w) begin
                errors++;
                $display("FAIL b2b_word_%0d: valid=%b instr=%h required 1/%h",
                         i, bus.out_valid, bus.out_instr, exp_w);
            end
        end
        bus.req_valid = 1'b0;
        drain_check("b2b_drain");
    endtask

    task automatic test_reset_in_hi();
        bus.out_ready = 1'b0;
        send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345FFF);
        checks++;
        if (dbg_state !== ST_HI) begin
            errors++;
            $display("FAIL rst_hi_pre: state=%0d required HI", dbg_state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL rst_hi_async: valid=%b instr=%h state=%0d required 0/00000000/IDLE",
                     bus.out_valid, bus.out_instr, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_hi_ready: req_ready=%b required 1", bus.req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_hi_no_addi_%0d: out_valid=%b instr=%h required 0",
                         i, bus.out_valid, bus.out_instr);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_i_type();
        test_b_type();
        test_formats();
        test_li();
        test_range();
        test_back_to_back();
        test_reset_in_hi();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
